spi_bus_ctrl: RTL and testbench

//  Transaction sequencer between spi_data_path and the on-chip memory bus. Latches the decoded

---
 rtl/spi_bus_ctrl.sv | 157 +++++++++++++++
 tb/tb_spi_bus_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_ctrl.sv
// Transaction sequencer between spi_data_path and the on-chip memory bus.
// Runs single/burst reads and writes on a req/ack handshake with timeout and error tracking.
module spi_bus_ctrl #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs_n,
    input  logic              address_ready,
    input  logic              data_ready,
    input  logic              miso_start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        status,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              busy,
    output logic [2:0]        err,
    output logic [15:0]       txn_cnt
);
    typedef enum logic [1:0] {IDLE, RD_ACC, WAIT_DATA, WR_ACC} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [2:0]        cur_st;
    logic [TO_W-1:0]   to_cnt;
    logic              abort_p;
    logic              in_acc, ack_hit, to_hit, frame_end;
    logic              issue, accept, addr_inc, cap_wdata;
    logic              late_set, proto_set;
    logic              unused_st;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // status[3] is reserved and deliberately not latched
    assign unused_st = status[3];

    assign in_acc    = (state == RD_ACC) || (state == WR_ACC);
    assign ack_hit   = in_acc && bus_req && bus_ack;
    assign to_hit    = in_acc && bus_req && !bus_ack && (to_cnt == TO_W'(TIMEOUT - 1));
    assign frame_end = abort_p || cs_n;
    assign late_set  = (state == RD_ACC) && miso_start;
    assign proto_set = (in_acc && data_ready) || ((state != IDLE) && address_ready);
    assign bus_addr  = cur_addr;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        accept    = 1'b0;
        addr_inc  = 1'b0;
        cap_wdata = 1'b0;
        case (state)
            IDLE: begin
                if (!cs_n && address_ready) begin
                    accept = 1'b1;
                    if (status[0])      state_nxt = RD_ACC;
                    else if (status[2]) state_nxt = WAIT_DATA;
                end
            end
            RD_ACC, WR_ACC: begin
                // Request goes out one clk after entry, which also guarantees an idle clk between requests
                if (!bus_req) begin
                    if (cs_n) state_nxt = IDLE;
                    else      issue     = 1'b1;
                end else if (ack_hit) begin
                    if (frame_end)               state_nxt = IDLE;
                    else if (state == RD_ACC)    state_nxt = WAIT_DATA;
                    else if (cur_st[1]) begin
                        addr_inc  = 1'b1;
                        state_nxt = cur_st[0] ? RD_ACC : WAIT_DATA;
                    end else                     state_nxt = IDLE;
                end else if (to_hit) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_DATA: begin
                if (cs_n) begin
                    state_nxt = IDLE;
                end else if (data_ready) begin
                    if (cur_st[2]) begin
                        cap_wdata = 1'b1;
                        state_nxt = WR_ACC;
                    end else if (cur_st[1]) begin
                        addr_inc = 1'b1;
                        if (cur_st[0]) state_nxt = RD_ACC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr  <= '0;
            cur_st    <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_wdata <= '0;
            rdata     <= '0;
            to_cnt    <= '0;
            abort_p   <= 1'b0;
            err       <= '0;
            txn_cnt   <= '0;
        end else begin
            if (accept) begin
                cur_addr <= addr;
                cur_st   <= status[2:0];
            end else if (addr_inc) begin
                cur_addr <= cur_addr + ADDR_W'(1);
            end

            if (cap_wdata) bus_wdata <= wdata;

            if (issue) begin
                bus_req <= 1'b1;
                bus_we  <= (state == WR_ACC);
                to_cnt  <= '0;
            end else if (ack_hit || to_hit) begin
                bus_req <= 1'b0;
                bus_we  <= 1'b0;
            end else if (bus_req) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (ack_hit) begin
                txn_cnt <= sat_inc16(txn_cnt);
                if (state == RD_ACC) rdata <= bus_rdata;
            end

            // cs_n seen with a request in flight: finish that transfer, then end the frame
            if (state == IDLE)                  abort_p <= 1'b0;
            else if (in_acc && bus_req && cs_n) abort_p <= 1'b1;

            if (accept) err <= '0;
            else        err <= err | {proto_set, to_hit, late_set};
        end
    end
endmodule

// File: tb/tb_spi_bus_ctrl.sv
// Self-checking bench for spi_bus_ctrl: bus responder plus a scoreboard of expected bus requests.
module tb_spi_bus_ctrl;
    logic        clk;
    logic        reset_n;
    logic        cs_n;
    logic        address_ready;
    logic        data_ready;
    logic        miso_start;
    logic [19:0] addr;
    logic [3:0]  status;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        bus_req;
    logic        bus_we;
    logic [19:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata = 16'h0000;
    logic        bus_ack   = 1'b0;
    logic        busy;
    logic [2:0]  err;
    logic [15:0] txn_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int ack_dly = 3;
    int req_age = 0;

    logic [36:0] exp_q[$];
    logic [36:0] got, held, exp_e;
    logic        req_q = 1'b0;

    spi_bus_ctrl #(.ADDR_W(20), .DATA_W(16), .TIMEOUT(255), .TO_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .address_ready(address_ready),
        .data_ready(data_ready), .miso_start(miso_start), .addr(addr), .status(status),
        .wdata(wdata), .rdata(rdata), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .busy(busy), .err(err), .txn_cnt(txn_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, got time %0t exp < 200000", $time);
        $fatal(1);
    end

    function automatic logic [15:0] mem_fn(input logic [19:0] a);
        if (a == 20'h00010) return 16'hBEEF;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    // Bus responder: ack_dly clks after req rises (0 = never ack)
    always @(negedge clk) begin
        if (!reset_n) begin
            bus_ack = 1'b0;
            req_age = 0;
        end else begin
            bus_ack = 1'b0;
            if (bus_req) begin
                req_age++;
                if (ack_dly != 0 && req_age == ack_dly) begin
                    bus_ack   = 1'b1;
                    bus_rdata = mem_fn(bus_addr);
                end
            end else begin
                req_age = 0;
            end
        end
    end

    // Scoreboard: pop an expected transfer on each new request; hold-stability while pending
    always @(negedge clk) begin
        got = {bus_we, bus_addr, bus_wdata};
        if (reset_n && bus_req && !req_q) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_req got %h exp none", got);
            end else begin
                exp_e = exp_q.pop_front();
                if (exp_e[36] ? (got !== exp_e) : (got[36:16] !== exp_e[36:16]))
                    $display("FAIL sb_req got %h exp %h", got, exp_e);
                else
                    n_pass++;
            end
        end else if (reset_n && bus_req && req_q) begin
            n_total++;
            if (got !== held) $display("FAIL req_stable got %h exp %h", got, held);
            else              n_pass++;
        end
        held  = got;
        req_q = reset_n && bus_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_addr(input logic [19:0] a, input logic [3:0] st);
        addr = a; status = st; address_ready = 1'b1;
        tick();
        address_ready = 1'b0;
    endtask

    task automatic pulse_data(input logic [15:0] w);
        wdata = w; data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
    endtask

    task automatic wait_req(input logic lvl, input int max);
        int n = 0;
        while (bus_req !== lvl && n < max) begin
            tick();
            n++;
        end
        if (bus_req !== lvl) begin
            n_total++;
            $display("FAIL wait_req got bus_req=%b exp %b within %0d clks", bus_req, lvl, max);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        n_total++; if ({rdata, bus_req, bus_we, bus_addr, bus_wdata, busy, err, txn_cnt} !== '0)
            $display("FAIL reset_outputs got %h exp 0", {rdata, bus_req, bus_we, bus_addr, bus_wdata, busy, err, txn_cnt}); else n_pass++;
        reset_n = 1'b1;
        repeat (2) tick();
        n_total++; if ({bus_req, busy, err, txn_cnt} !== '0)
            $display("FAIL reset_release got %h exp 0", {bus_req, busy, err, txn_cnt}); else n_pass++;
    endtask

    task automatic test_read();
        ack_dly = 3;
        exp_q.push_back({1'b0, 20'h00010, 16'h0000});
        cs_n = 1'b0;
        pulse_addr(20'h00010, 4'b0001);
        wait_req(1'b1, 10);
        wait_req(1'b0, 20);
        n_total++; if (rdata !== 16'hBEEF) $display("FAIL read_rdata got %h exp BEEF", rdata); else n_pass++;
        n_total++; if (txn_cnt !== 16'd1) $display("FAIL read_txn got %0d exp 1", txn_cnt); else n_pass++;
        miso_start = 1'b1; tick(); miso_start = 1'b0;
        n_total++; if (err !== 3'b000) $display("FAIL read_err got %b exp 000", err); else n_pass++;
        pulse_data(16'h0000);
        n_total++; if (busy !== 1'b0) $display("FAIL read_idle got busy=%b exp 0", busy); else n_pass++;
        cs_n = 1'b1; tick();
    endtask

    task automatic test_write();
        ack_dly = 2;
        exp_q.push_back({1'b1, 20'h00234, 16'h1234});
        cs_n = 1'b0;
        pulse_addr(20'h00234, 4'b0100);
        repeat (2) tick();
        n_total++; if ({busy, bus_req} !== 2'b10) $display("FAIL write_wait got busy,req=%b exp 10", {busy, bus_req}); else n_pass++;
        pulse_data(16'h1234);
        wait_req(1'b1, 10);
        n_total++; if (bus_we !== 1'b1) $display("FAIL write_we got %b exp 1", bus_we); else n_pass++;
        wait_req(1'b0, 20);
        n_total++; if (bus_wdata !== 16'h1234) $display("FAIL write_wdata got %h exp 1234", bus_wdata); else n_pass++;
        n_total++; if ({busy, txn_cnt} !== {1'b0, 16'd2}) $display("FAIL write_done got busy=%b txn=%0d exp 0/2", busy, txn_cnt); else n_pass++;
        n_total++; if (rdata !== 16'hBEEF) $display("FAIL write_rdata_held got %h exp BEEF", rdata); else n_pass++;
        cs_n = 1'b1; tick();
    endtask

    task automatic test_burst();
        ack_dly = 2;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({1'b0, 20'hFFFFF + 20'(i), 16'h0000});
            exp_q.push_back({1'b1, 20'hFFFFF + 20'(i), 16'hC000 | 16'(i)});
        end
        cs_n = 1'b0;
        pulse_addr(20'hFFFFF, 4'b0111);
        for (int i = 0; i < 3; i++) begin
            wait_req(1'b1, 10);
            wait_req(1'b0, 20);
            n_total++; if (rdata !== mem_fn(20'hFFFFF + 20'(i)))
                $display("FAIL burst_rdata%0d got %h exp %h", i, rdata, mem_fn(20'hFFFFF + 20'(i))); else n_pass++;
            pulse_data(16'hC000 | 16'(i));
            wait_req(1'b1, 10);
            if (i == 2) cs_n = 1'b1;
            wait_req(1'b0, 20);
        end
        repeat (4) tick();
        n_total++; if ({busy, bus_req} !== 2'b00) $display("FAIL burst_end got busy,req=%b exp 00", {busy, bus_req}); else n_pass++;
        n_total++; if (txn_cnt !== 16'd8) $display("FAIL burst_txn got %0d exp 8", txn_cnt); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL burst_missing got %0d pending exp 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_timeout();
        int n = 0;
        ack_dly = 0;
        exp_q.push_back({1'b0, 20'h00777, 16'h0000});
        cs_n = 1'b0;
        pulse_addr(20'h00777, 4'b0001);
        wait_req(1'b1, 10);
        while (bus_req && n < 400) begin
            tick();
            n++;
        end
        n_total++; if (n != 255) $display("FAIL timeout_len got %0d exp 255", n); else n_pass++;
        n_total++; if (err !== 3'b010) $display("FAIL timeout_err got %b exp 010", err); else n_pass++;
        n_total++; if ({busy, txn_cnt} !== {1'b0, 16'd8}) $display("FAIL timeout_state got busy=%b txn=%0d exp 0/8", busy, txn_cnt); else n_pass++;
        cs_n = 1'b1; tick();
        ack_dly = 3;
    endtask

    task automatic test_cs_abort();
        ack_dly = 6;
        exp_q.push_back({1'b0, 20'h00055, 16'h0000});
        cs_n = 1'b0;
        pulse_addr(20'h00055, 4'b0011);
        n_total++; if (err !== 3'b000) $display("FAIL abort_err_clear got %b exp 000", err); else n_pass++;
        wait_req(1'b1, 10);
        cs_n = 1'b1;
        wait_req(1'b0, 20);
        n_total++; if (busy !== 1'b0) $display("FAIL abort_idle got busy=%b exp 0", busy); else n_pass++;
        n_total++; if ({rdata, txn_cnt} !== {mem_fn(20'h00055), 16'd9})
            $display("FAIL abort_read got rdata=%h txn=%0d exp %h/9", rdata, txn_cnt, mem_fn(20'h00055)); else n_pass++;
        pulse_data(16'h0000);
        repeat (5) tick();
        n_total++; if ({busy, bus_req} !== 2'b00) $display("FAIL abort_no_more got busy,req=%b exp 00", {busy, bus_req}); else n_pass++;
    endtask

    task automatic test_late_err();
        ack_dly = 4;
        exp_q.push_back({1'b0, 20'h00066, 16'h0000});
        cs_n = 1'b0;
        pulse_addr(20'h00066, 4'b0001);
        miso_start = 1'b1; tick(); miso_start = 1'b0;
        n_total++; if (err !== 3'b001) $display("FAIL late_err got %b exp 001", err); else n_pass++;
        n_total++; if (rdata !== mem_fn(20'h00055)) $display("FAIL late_rdata got %h exp %h", rdata, mem_fn(20'h00055)); else n_pass++;
        wait_req(1'b1, 10);
        wait_req(1'b0, 20);
        n_total++; if (rdata !== mem_fn(20'h00066)) $display("FAIL late_rdata_after got %h exp %h", rdata, mem_fn(20'h00066)); else n_pass++;
        pulse_data(16'h0000);
        cs_n = 1'b1; tick();
        cs_n = 1'b0;
        pulse_addr(20'h00010, 4'b0000);
        n_total++; if ({busy, err} !== 4'b0000) $display("FAIL late_clear got busy,err=%b exp 0000", {busy, err}); else n_pass++;
        cs_n = 1'b1; tick();
    endtask

    task automatic test_proto_err();
        ack_dly = 4;
        exp_q.push_back({1'b0, 20'h00077, 16'h0000});
        cs_n = 1'b0;
        pulse_addr(20'h00077, 4'b0001);
        pulse_addr(20'h00099, 4'b0100);
        pulse_data(16'hDEAD);
        n_total++; if ({busy, err} !== 4'b1100) $display("FAIL proto_err got busy,err=%b exp 1100", {busy, err}); else n_pass++;
        wait_req(1'b1, 10);
        wait_req(1'b0, 20);
        n_total++; if (rdata !== mem_fn(20'h00077)) $display("FAIL proto_rdata got %h exp %h", rdata, mem_fn(20'h00077)); else n_pass++;
        pulse_data(16'h0000);
        n_total++; if ({busy, txn_cnt} !== {1'b0, 16'd11}) $display("FAIL proto_end got busy=%b txn=%0d exp 0/11", busy, txn_cnt); else n_pass++;
        cs_n = 1'b1;
        repeat (3) tick();
        n_total++; if (exp_q.size() != 0) $display("FAIL sb_drain got %0d pending exp 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        reset_n = 1'b0; cs_n = 1'b1; address_ready = 1'b0; data_ready = 1'b0;
        miso_start = 1'b0; addr = '0; status = '0; wdata = '0;
        test_reset();
        test_read();
        test_write();
        test_burst();
        test_timeout();
        test_cs_abort();
        test_late_err();
        test_proto_err();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
